nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands by reusing a single 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Valid/ready handshake on both input and output, so it drops into pipelines where area matters more than latency.
- The slice is the team's 4-bit ripple-carry full adder, instantiated once inside this block.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived local constant; number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, c_in are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered result
- c_out  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: a[MSB]^b[MSB]^sum[MSB]^c_out, computed on captured operands
- busy  output  1  high while in RUN

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, busy=1.
  - DONE: out_valid=1, in_ready=0.
- Reset (rst high at an edge), from any state including mid-RUN:
  - state to IDLE; sum=0, c_out=0, ovf=0, out_valid=0, busy=0.
  - nibble index=0, carry reg=0, operand regs=0.
  - in_ready=1 in the cycle after the reset edge.
  - Any in-flight operation is discarded.
- IDLE:
  - On edge with in_valid & in_ready: capture a, b into operand regs; carry reg <= c_in; index <= 0; sum <= 0; go to RUN.
  - in_valid low: stay in IDLE.
- RUN, each edge:
  - Slice adds a_reg[4i+3:4i], b_reg[4i+3:4i] and carry reg (i = index).
  - sum[4i+3:4i] <= slice sum; carry reg <= slice carry; index++.
  - When index==NIBBLES-1: c_out <= slice carry, ovf computed from final values, go to DONE.
- Latency: acceptance on edge k gives out_valid high after edge k+NIBBLES (4 cycles for WIDTH=16).
- DONE:
  - sum, c_out, ovf held stable while out_valid & !out_ready.
  - On edge with out_ready high: go to IDLE, out_valid=0.
  - No same-cycle re-accept; in_ready rises the cycle after the output handshake.
  - Max throughput: one result per NIBBLES+2 cycles.
- Input changes on a/b/c_in while RUN or DONE have no effect. in_valid while in_ready=0 is ignored; no queuing.
- sum is meaningful only while out_valid=1. Partial nibbles are visible during RUN and must not be consumed.
- Arithmetic: {c_out,sum} == a + b + c_in, modulo 2^(WIDTH+1); unsigned. ovf is the two's-complement overflow indication.
- WIDTH=4 degenerates to a single RUN cycle; the same rules apply.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, c_in=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, c_out=0, ovf=0.
- a=0xFFFF, b=0x0001, c_in=0 (carry ripples through all nibbles) -> sum=0x0000, c_out=1, ovf=0.
- a=0x7FFF, b=0x0000, c_in=1 -> sum=0x8000, c_out=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new operands -> sum/c_out/ovf unchanged, in_ready=0, new operands dropped; raise out_ready -> IDLE, in_ready=1 next cycle.
- rst asserted after 2 RUN cycles -> next cycle out_valid=0, sum=0, busy=0, in_ready=1; a following 0x00FF+0x0001 transaction yields 0x0100, c_out=0.
- Back-to-back with out_ready tied high and in_valid held high over 3 operand sets -> accepts spaced exactly 6 cycles apart, three correct results in order.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// 4-bit ripple-carry slice, with valid/ready on both sides.

module nibble_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per clock, busy high
// DONE  | result held until downstream takes it, out_valid high
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] slice_s;
  logic       slice_co;

  // Steer the current nibble into the shared slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        a_nib = a_reg[n*4 +: 4];
        b_nib = b_reg[n*4 +: 4];
      end
    end
  end

  nibble_rca4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry         <= 1'b0;
      idx           <= '0;
      c_out_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            carry        <= bus.c_in;
            idx          <= '0;
            sum_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) sum_reg[n*4 +: 4] <= slice_s;
          end
          carry <= slice_co;
          if (idx == IW'(NIBBLES - 1)) begin
            // On the last nibble slice_s[3] is the result MSB.
            c_out_reg     <= slice_co;
            ovf_reg       <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_s[3] ^ slice_co;
            idx           <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16) against an
// arithmetic reference model.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] last_sum;
  logic        last_c;
  logic        last_o;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} from integer arithmetic and signed range.
  function automatic logic [17:0] ref_add(input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci);
    int u;
    int s;
    int sa;
    int sb;
    logic [15:0] rs;
    logic        rc;
    logic        ro;
    u  = int'(av) + int'(bv) + int'(ci);
    rs = 16'(u);
    rc = (u > 65535);
    sa = av[15] ? int'(av) - 65536 : int'(av);
    sb = bv[15] ? int'(bv) - 65536 : int'(bv);
    s  = sa + sb + int'(ci);
    ro = (s < -32768) || (s > 32767);
    return {ro, rc, rs};
  endfunction

  // One full transaction: accept, latency, optional backpressure, drain.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input int hold);
    logic [17:0] e;
    int n;
    e = ref_add(av, bv, ci);
    bus.a        = av;
    bus.b        = bv;
    bus.c_in     = ci;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.c_in     = 1'($urandom);
    check("busy_run", 32'(bus.busy), 32'd1);
    check("in_ready_run", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    for (int h = 0; h < hold; h++) begin
      check("hold_sum", 32'(bus.sum), 32'(e[15:0]));
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    check("sum", 32'(bus.sum), 32'(e[15:0]));
    check("c_out", 32'(bus.c_out), 32'(e[16]));
    check("ovf", 32'(bus.ovf), 32'(e[17]));
    check("busy_done", 32'(bus.busy), 32'd0);
    last_sum = bus.sum;
    last_c   = bus.c_out;
    last_o   = bus.ovf;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [17:0] e;
    logic [15:0] ba [3];
    logic [15:0] bb [3];
    logic        bc [3];
    int          acc_cyc [3];
    int          idx;
    int          r;
    int          cyc;
    logic        acc;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    check("d1_sum", 32'(last_sum), 32'h5555);
    check("d1_c", 32'(last_c), 32'd0);
    check("d1_o", 32'(last_o), 32'd0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    check("d2_sum", 32'(last_sum), 32'h0000);
    check("d2_c", 32'(last_c), 32'd1);
    check("d2_o", 32'(last_o), 32'd0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 0);
    check("d3_sum", 32'(last_sum), 32'h8000);
    check("d3_c", 32'(last_c), 32'd0);
    check("d3_o", 32'(last_o), 32'd1);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
    check("d4_sum", 32'(last_sum), 32'h0000);
    check("d4_c", 32'(last_c), 32'd1);
    check("d4_o", 32'(last_o), 32'd1);

    // Backpressure with a stray in_valid pulse in DONE.
    e = ref_add(16'h0F0F, 16'h0101, 1'b1);
    bus.a = 16'h0F0F; bus.b = 16'h0101; bus.c_in = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.a = 16'hAAAA; bus.b = 16'h5555; bus.c_in = 1'b1;
      check("bp_sum", 32'(bus.sum), 32'(e[15:0]));
      check("bp_c", 32'(bus.c_out), 32'(e[16]));
      check("bp_o", 32'(bus.ovf), 32'(e[17]));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    check("bp_still_valid", 32'(bus.out_valid), 32'd1);
    check("bp_sum_final", 32'(bus.sum), 32'(e[15:0]));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp_idle", 32'(bus.in_ready), 32'd1);
    check("bp_no_result", 32'(bus.out_valid), 32'd0);
    step();
    check("bp_dropped", 32'(bus.busy), 32'd0);

    // Reset in the middle of RUN.
    bus.a = 16'hABCD; bus.b = 16'h1111; bus.c_in = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(16'h00FF, 16'h0001, 1'b0, 0);
    check("post_rst_sum", 32'(last_sum), 32'h0100);
    check("post_rst_c", 32'(last_c), 32'd0);

    // Randomized transactions with random backpressure.
    for (int t = 0; t < 20; t++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back streaming with out_ready tied high.
    for (int i = 0; i < 3; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
      bc[i] = 1'($urandom);
    end
    idx = 0; r = 0; cyc = 0;
    bus.out_ready = 1'b1;
    bus.a = ba[0]; bus.b = bb[0]; bus.c_in = bc[0]; bus.in_valid = 1'b1;
    while ((idx < 3 || r < 3) && cyc < 100) begin
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid === 1'b1 && r < 3) begin
        e = ref_add(ba[r], bb[r], bc[r]);
        check("b2b_sum", 32'(bus.sum), 32'(e[15:0]));
        check("b2b_c", 32'(bus.c_out), 32'(e[16]));
        check("b2b_o", 32'(bus.ovf), 32'(e[17]));
        r++;
      end
      step();
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          bus.a = ba[idx]; bus.b = bb[idx]; bus.c_in = bc[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b0;
    check("b2b_timeout", 32'(cyc < 100), 32'd1);
    check("b2b_results", 32'(r), 32'd3);
    if (idx == 3) begin
      check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end else begin
      check("b2b_accepts", 32'(idx), 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
